// File: rtl/step_deserializer.sv
// Assembles 560-bit trace steps from a 32-bit witness word stream and presents
// each completed step on a valid/ready port that feeds fetch directly.
module step_deserializer #(
    parameter int STEP_W     = 560,
    parameter int WORD_W     = 32,
    parameter int STEP_WORDS = (STEP_W + WORD_W - 1) / WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [STEP_W-1:0] step,
    output logic              step_valid,
    input  logic              step_ready,
    output logic [31:0]       step_count,
    output logic              pad_err,
    output logic              busy
);

    localparam int LAST   = STEP_WORDS - 1;
    localparam int ACC_W  = LAST * WORD_W;
    localparam int TAIL_W = STEP_W - ACC_W;
    localparam logic [4:0] LAST_IDX = 5'(LAST);

    logic [4:0]                  idx;
    logic [LAST-1:0][WORD_W-1:0] acc;
    logic                        accept;
    logic                        last_beat;
    logic                        final_accept;
    logic                        consume;

    assign last_beat    = (idx == LAST_IDX);
    assign in_ready     = !(last_beat && step_valid && !step_ready);
    assign accept       = in_valid && in_ready;
    assign final_accept = accept && last_beat;
    assign consume      = step_valid && step_ready;
    assign busy         = (idx != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 5'd0;
        end else if (accept) begin
            idx <= last_beat ? 5'd0 : idx + 5'd1;
        end
    end

    // One write-enabled slot per non-final beat; the final beat bypasses the
    // accumulator and lands straight in the output register.
    for (genvar k = 0; k < LAST; k++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                acc[k] <= '0;
            end else if (accept && idx == 5'(k)) begin
                acc[k] <= in_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step       <= '0;
            step_valid <= 1'b0;
        end else if (final_accept) begin
            // Reload wins over a same-edge consume so the port stays full.
            step       <= {in_word[TAIL_W-1:0], acc};
            step_valid <= 1'b1;
        end else if (consume) begin
            step_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_count <= 32'd0;
        end else if (consume) begin
            step_count <= step_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_err <= 1'b0;
        end else if (final_accept && in_word[WORD_W-1:TAIL_W] != '0) begin
            pad_err <= 1'b1;
        end
    end

endmodule
